// File: rtl/ssp_pkg.sv
// Shared SSP definitions: receive FSM states and clocking constants used by
// the receive and transmit paths.
package ssp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } ssp_state_e;

  localparam int SSP_DEFAULT_WIDTH = 8;
  // sspclkin runs at pclk / SSP_CLK_DIV
  localparam int SSP_CLK_DIV       = 2;

endpackage

// File: rtl/ssp_receiver_if.sv
// RX FIFO write port of the SSP receiver: write strobe and data toward the
// FIFO, full status back from it.
interface ssp_receiver_if #(
  parameter int WIDTH = 8
);

  logic             rxfifo_full;
  logic             rxfifo_wr;
  logic [WIDTH-1:0] rxdata;

  modport master (
    input  rxfifo_full,
    output rxfifo_wr,
    output rxdata
  );

  modport slave (
    output rxfifo_full,
    input  rxfifo_wr,
    input  rxdata
  );

endinterface

// File: rtl/ssp_edge_det.sv
// Registers the pclk-derived serial clock and produces one-pclk rise/fall
// pulses; shared by the SSP receive and transmit paths.
module ssp_edge_det (
  input  logic pclk,
  input  logic clear,
  input  logic sclk,
  output logic sclk_q,
  output logic rise,
  output logic fall
);

  logic sclk_q_r;

  // one-cycle delayed copy of the serial clock
  always_ff @(posedge pclk) begin
    if (!clear) begin
      sclk_q_r <= 1'b0;
    end else begin
      sclk_q_r <= sclk;
    end
  end

  assign sclk_q = sclk_q_r;
  assign rise   = ~sclk_q_r & sclk;
  assign fall   = sclk_q_r & ~sclk;

endmodule

// File: rtl/ssp_receiver.sv
// SSP receive front end: deserialises MSB-first frames on sspclkin falling
// edges and pushes each complete word into the RX FIFO, flagging overruns.
module ssp_receiver
  import ssp_pkg::*;
#(
  parameter int WIDTH = SSP_DEFAULT_WIDTH,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic                 pclk,
  input  logic                 clear,
  input  logic                 sspclkin,
  input  logic                 sspfssin,
  input  logic                 ssprxd,
  input  logic                 ror_clr,
  output logic                 ssprorintr,
  output logic                 rx_busy,
  ssp_receiver_if.master       fifo
);

  localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

  ssp_state_e       state_r;
  ssp_state_e       state_nxt_s;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] shift_nxt_s;
  logic [CNTW-1:0]  cnt_r;
  logic [CNTW-1:0]  cnt_nxt_s;
  logic [WIDTH-1:0] word_s;
  logic             latch_s;
  logic [WIDTH-1:0] rxdata_r;
  logic             push_pend_r;
  logic             rxfifo_wr_r;
  logic             ror_r;
  logic             sclk_q_unused_s;
  logic             sclk_rise_unused_s;
  logic             sclk_fall_s;

  ssp_edge_det u_edge_det (
    .pclk   (pclk),
    .clear  (clear),
    .sclk   (sspclkin),
    .sclk_q (sclk_q_unused_s),
    .rise   (sclk_rise_unused_s),
    .fall   (sclk_fall_s)
  );

  // shift register already holds the upper bits; append the current sample
  assign word_s = {shift_r[WIDTH-2:0], ssprxd};

  // next-state, shift and bit-count logic; everything advances only on a fall
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    if (sclk_fall_s) begin
      case (state_r)
        IDLE: begin
          if (sspfssin) begin
            state_nxt_s = ARMED;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (sspfssin) begin
            state_nxt_s = ARMED;
          end else begin
            shift_nxt_s = {{(WIDTH-1){1'b0}}, ssprxd};
            cnt_nxt_s   = CNTW'(1);
            state_nxt_s = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_r == LAST_BIT) begin
            latch_s     = 1'b1;
            shift_nxt_s = {WIDTH{1'b0}};
            cnt_nxt_s   = {CNTW{1'b0}};
            state_nxt_s = sspfssin ? ARMED : IDLE;
          end else if (sspfssin) begin
            // frame sync inside a word: drop the partial word and re-arm
            shift_nxt_s = {WIDTH{1'b0}};
            cnt_nxt_s   = {CNTW{1'b0}};
            state_nxt_s = ARMED;
          end else begin
            shift_nxt_s = word_s;
            cnt_nxt_s   = cnt_r + CNTW'(1);
            state_nxt_s = SHIFT;
          end
        end
        default: begin
          shift_nxt_s = {WIDTH{1'b0}};
          cnt_nxt_s   = {CNTW{1'b0}};
          state_nxt_s = IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state, shift register and bit counter
  always_ff @(posedge pclk) begin
    if (!clear) begin
      state_r <= IDLE;
      shift_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNTW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // word capture, FIFO push one cycle later, sticky overrun (set beats clear)
  always_ff @(posedge pclk) begin
    if (!clear) begin
      rxdata_r    <= {WIDTH{1'b0}};
      push_pend_r <= 1'b0;
      rxfifo_wr_r <= 1'b0;
      ror_r       <= 1'b0;
    end else begin
      rxdata_r    <= latch_s ? word_s : rxdata_r;
      push_pend_r <= latch_s;
      rxfifo_wr_r <= push_pend_r & ~fifo.rxfifo_full;
      if (push_pend_r && fifo.rxfifo_full) begin
        ror_r <= 1'b1;
      end else if (ror_clr) begin
        ror_r <= 1'b0;
      end else begin
        ror_r <= ror_r;
      end
    end
  end

  assign fifo.rxfifo_wr = rxfifo_wr_r;
  assign fifo.rxdata    = rxdata_r;
  assign ssprorintr     = ror_r;
  assign rx_busy        = (state_r != IDLE);

endmodule

// File: tb/tb_ssp_receiver.sv
// Directed bench for ssp_receiver: an 8-bit and a 12-bit instance share the
// serial pins; each is held in reset while the other is being exercised.
module tb_ssp_receiver;
  import ssp_pkg::*;

  logic pclk;
  logic clear8;
  logic clear12;
  logic sspclkin;
  logic sspfssin;
  logic ssprxd;
  logic ror_clr;
  logic ror8;
  logic busy8;
  logic ror12;
  logic busy12;

  ssp_receiver_if #(.WIDTH(8))  fifo8 ();
  ssp_receiver_if #(.WIDTH(12)) fifo12 ();

  ssp_receiver #(.WIDTH(SSP_DEFAULT_WIDTH)) dut8 (
    .pclk       (pclk),
    .clear      (clear8),
    .sspclkin   (sspclkin),
    .sspfssin   (sspfssin),
    .ssprxd     (ssprxd),
    .ror_clr    (ror_clr),
    .ssprorintr (ror8),
    .rx_busy    (busy8),
    .fifo       (fifo8)
  );

  ssp_receiver #(.WIDTH(12)) dut12 (
    .pclk       (pclk),
    .clear      (clear12),
    .sspclkin   (sspclkin),
    .sspfssin   (sspfssin),
    .ssprxd     (ssprxd),
    .ror_clr    (ror_clr),
    .ssprorintr (ror12),
    .rx_busy    (busy12),
    .fifo       (fifo12)
  );

  int          check_cnt = 0;
  int          pass_cnt  = 0;
  int          cyc       = 0;
  logic [15:0] q8[$];
  int          c8[$];
  logic [15:0] q12[$];
  logic        watch_busy = 1'b0;
  logic        busy_low_seen = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // record every FIFO write with its cycle number
  always @(negedge pclk) begin
    if (fifo8.rxfifo_wr) begin
      q8.push_back(16'(fifo8.rxdata));
      c8.push_back(cyc);
    end
    if (fifo12.rxfifo_wr) begin
      q12.push_back(16'(fifo12.rxdata));
    end
    if (watch_busy && !busy8) begin
      busy_low_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] q8_at(input int i);
    return (i < q8.size()) ? q8[i] : 16'hDEAD;
  endfunction

  // one sspclkin period (SSP_CLK_DIV pclks): rise with new fss/data, then fall
  task automatic sper(input logic fss, input logic d);
    @(posedge pclk); #1;
    sspclkin = 1'b1;
    sspfssin = fss;
    ssprxd   = d;
    repeat (SSP_CLK_DIV - 1) @(posedge pclk);
    #1;
    sspclkin = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic fss_on_lsb);
    for (int i = n - 1; i >= 0; i--) begin
      sper((i == 0) ? fss_on_lsb : 1'b0, w[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    clear8 = 1'b0;
    clear12 = 1'b0;
    sspclkin = 1'b0;
    sspfssin = 1'b0;
    ssprxd = 1'b0;
    ror_clr = 1'b0;
    fifo8.rxfifo_full = 1'b0;
    fifo12.rxfifo_full = 1'b0;
    idle(2);
    chk("reset_rxdata", 16'(fifo8.rxdata), 16'h0000);
    chk("reset_wr", 16'(fifo8.rxfifo_wr), 16'h0000);
    chk("reset_ror", 16'(ror8), 16'h0000);
    chk("reset_busy", 16'(busy8), 16'h0000);
    clear8 = 1'b1;
    idle(1);

    // single frame 8'hA5 and its push latency
    sper(1'b1, 1'b0);
    send_word(16'h00A5, 8, 1'b0);
    idle(1);
    chk("a5_wr_at_sample", 16'(fifo8.rxfifo_wr), 16'h0000);
    chk("a5_rxdata", 16'(fifo8.rxdata), 16'h00A5);
    idle(1);
    chk("a5_wr_pulse", 16'(fifo8.rxfifo_wr), 16'h0001);
    idle(1);
    chk("a5_wr_end", 16'(fifo8.rxfifo_wr), 16'h0000);
    chk("a5_busy_end", 16'(busy8), 16'h0000);
    chk("a5_count", 16'(q8.size()), 16'd1);

    // back-to-back: fss overlaps the 3C LSB and lasts one more period
    q8.delete();
    c8.delete();
    sper(1'b1, 1'b0);
    send_word(16'h003C, 8, 1'b1);
    watch_busy = 1'b1;
    sper(1'b1, 1'b0);
    send_word(16'h00C3, 8, 1'b0);
    watch_busy = 1'b0;
    idle(3);
    chk("b2b_count", 16'(q8.size()), 16'd2);
    chk("b2b_first", q8_at(0), 16'h003C);
    chk("b2b_second", q8_at(1), 16'h00C3);
    chk("b2b_spacing", (c8.size() == 2) ? 16'(c8[1] - c8[0]) : 16'hFFFF, 16'd18);
    chk("b2b_no_idle", 16'(busy_low_seen), 16'h0000);

    // overrun on 8'hFF, then a good frame with the flag still set
    q8.delete();
    fifo8.rxfifo_full = 1'b1;
    sper(1'b1, 1'b0);
    send_word(16'h00FF, 8, 1'b0);
    idle(3);
    fifo8.rxfifo_full = 1'b0;
    chk("ovr_no_write", 16'(q8.size()), 16'd0);
    chk("ovr_flag", 16'(ror8), 16'h0001);
    chk("ovr_rxdata", 16'(fifo8.rxdata), 16'h00FF);
    sper(1'b1, 1'b0);
    send_word(16'h0001, 8, 1'b0);
    idle(3);
    chk("ovr_good_write", q8_at(0), 16'h0001);
    chk("ovr_flag_sticky", 16'(ror8), 16'h0001);
    ror_clr = 1'b1;
    idle(1);
    ror_clr = 1'b0;
    chk("ovr_cleared", 16'(ror8), 16'h0000);

    // new overrun coincident with ror_clr: set wins
    fifo8.rxfifo_full = 1'b1;
    sper(1'b1, 1'b0);
    send_word(16'h007E, 8, 1'b0);
    idle(1);
    ror_clr = 1'b1;
    idle(1);
    ror_clr = 1'b0;
    fifo8.rxfifo_full = 1'b0;
    chk("ovr_set_wins", 16'(ror8), 16'h0001);
    chk("ovr_coinc_no_write", 16'(q8.size()), 16'd1);

    // framing abort after 4 bits, then 8'h5A
    q8.delete();
    sper(1'b1, 1'b0);
    sper(1'b0, 1'b1);
    sper(1'b0, 1'b1);
    sper(1'b0, 1'b0);
    sper(1'b0, 1'b0);
    sper(1'b1, 1'b0);
    send_word(16'h005A, 8, 1'b0);
    idle(3);
    chk("abort_count", 16'(q8.size()), 16'd1);
    chk("abort_next_word", q8_at(0), 16'h005A);

    // reset after 3 bits of a frame, then 8'h81
    q8.delete();
    sper(1'b1, 1'b0);
    sper(1'b0, 1'b1);
    sper(1'b0, 1'b1);
    sper(1'b0, 1'b1);
    clear8 = 1'b0;
    idle(1);
    chk("midrst_rxdata", 16'(fifo8.rxdata), 16'h0000);
    chk("midrst_wr", 16'(fifo8.rxfifo_wr), 16'h0000);
    chk("midrst_ror", 16'(ror8), 16'h0000);
    chk("midrst_busy", 16'(busy8), 16'h0000);
    clear8 = 1'b1;
    idle(1);
    sper(1'b1, 1'b0);
    send_word(16'h0081, 8, 1'b0);
    idle(3);
    chk("midrst_count", 16'(q8.size()), 16'd1);
    chk("midrst_next_word", q8_at(0), 16'h0081);

    // 12-bit instance, frame 12'hABC
    clear8 = 1'b0;
    clear12 = 1'b1;
    idle(1);
    sper(1'b1, 1'b0);
    send_word(16'h0ABC, 12, 1'b0);
    idle(3);
    chk("w12_count", 16'(q12.size()), 16'd1);
    chk("w12_word", (q12.size() > 0) ? q12[0] : 16'hDEAD, 16'h0ABC);
    chk("w12_rxdata", 16'(fifo12.rxdata), 16'h0ABC);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
